// File: rtl/cc_level_sequencer_pkg.sv
// Shared definitions for the track sequencer: FSM state encoding, phase
// numbering (the level ROM uses the same numbering), default phase lengths
// and a helper that picks the banner phase to replay after a crash.
package cc_level_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_CRASH = 2'd2,
      ST_WIN   = 2'd3
   } seq_state_t;

   localparam logic [2:0] PH_NONE = 3'd0;
   localparam logic [2:0] PH_BN1  = 3'd1;
   localparam logic [2:0] PH_LV1  = 3'd2;
   localparam logic [2:0] PH_BN2  = 3'd3;
   localparam logic [2:0] PH_LV2  = 3'd4;
   localparam logic [2:0] PH_BN3  = 3'd5;
   localparam logic [2:0] PH_LV3  = 3'd6;

   localparam int DEF_LEN_P1     = 8;
   localparam int DEF_LEN_P2     = 10;
   localparam int DEF_LEN_P3     = 8;
   localparam int DEF_LEN_P4     = 15;
   localparam int DEF_LEN_P5     = 8;
   localparam int DEF_LEN_P6     = 20;
   localparam int DEF_CRASH_HOLD = 4;

   // Odd phases are banners and replay themselves; a level falls back to the
   // banner that precedes it.
   function automatic logic [2:0] replay_phase(input logic [2:0] cur);
      if (cur == PH_NONE)
         return PH_BN1;
      return cur[0] ? cur : cur - 3'd1;
   endfunction

endpackage

// File: rtl/cc_level_sequencer_row_counter.sv
// Row counter for the current phase.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_clr          : clear to 0; together with i_en it restarts at row 1
//   i_en           : advance one row (holds at the terminal count)
//   i_len          : number of rows in the current phase
//   o_count        : current row index
//   o_tc           : terminal count, last row of the phase reached
module cc_level_sequencer_row_counter (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_clr,
   input  logic       i_en,
   input  logic [4:0] i_len,
   output logic [4:0] o_count,
   output logic       o_tc
);

   logic [4:0] r_count;

   assign o_tc    = (r_count >= i_len);
   assign o_count = r_count;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_count <= 5'd0;
      else if (i_clr)
         r_count <= i_en ? 5'd1 : 5'd0;
      else if (i_en && !o_tc)
         r_count <= r_count + 5'd1;
   end

endmodule

// File: rtl/cc_level_sequencer.sv
// Track sequencer upstream of the level ROM. Advances a row index within a
// phase on every unpaused scroll tick and strobes RowLoad so the matrix shift
// register samples the ROM row; handles start, pause, crash-restart and win.
//   CLOCK_50 / RESET_InLow : clock, asynchronous active-low reset
//   Tick/Start/Pause/Crash : control inputs (Tick is a 1-cycle pulse)
//   Current_Out (3)        : phase index, 0 = no track
//   Progress_Out (5)       : row index, 0 = blank row
//   RowLoad/PhaseDone/Win  : registered strobes / status
//
// state    | meaning
// ST_IDLE  | after reset, waiting for Start, no track
// ST_RUN   | scrolling; unpaused ticks advance rows and phases
// ST_CRASH | frozen for CRASH_HOLD unpaused ticks, then replay the banner
// ST_WIN   | last row of phase 6 passed, Win high until Start
module cc_level_sequencer
   import cc_level_sequencer_pkg::*;
#(
   parameter int LEN_P1     = DEF_LEN_P1,
   parameter int LEN_P2     = DEF_LEN_P2,
   parameter int LEN_P3     = DEF_LEN_P3,
   parameter int LEN_P4     = DEF_LEN_P4,
   parameter int LEN_P5     = DEF_LEN_P5,
   parameter int LEN_P6     = DEF_LEN_P6,
   parameter int CRASH_HOLD = DEF_CRASH_HOLD
) (
   input  logic       CC_LEVELSEQUENCER_CLOCK_50,
   input  logic       CC_LEVELSEQUENCER_RESET_InLow,
   input  logic       CC_LEVELSEQUENCER_Tick_In,
   input  logic       CC_LEVELSEQUENCER_Start_In,
   input  logic       CC_LEVELSEQUENCER_Pause_In,
   input  logic       CC_LEVELSEQUENCER_Crash_In,
   output logic [2:0] CC_LEVELSEQUENCER_Current_Out,
   output logic [4:0] CC_LEVELSEQUENCER_Progress_Out,
   output logic       CC_LEVELSEQUENCER_RowLoad_Out,
   output logic       CC_LEVELSEQUENCER_PhaseDone_Out,
   output logic       CC_LEVELSEQUENCER_Win_Out
);

   localparam logic [3:0] HOLD_LAST = 4'(CRASH_HOLD - 1);

   seq_state_t r_state;
   logic [2:0] r_current;
   logic [3:0] r_crash_cnt;
   logic       r_row_load;
   logic       r_phase_done;
   logic       r_win;

   logic [4:0] w_len;
   logic [4:0] w_count;
   logic       w_tc;
   logic       w_cnt_clr;
   logic       w_cnt_en;
   logic       w_tick_ok;

   assign w_tick_ok = CC_LEVELSEQUENCER_Tick_In & ~CC_LEVELSEQUENCER_Pause_In;

   always_comb begin
      w_len = 5'd0;
      case (r_current)
         PH_BN1:  w_len = 5'(LEN_P1);
         PH_LV1:  w_len = 5'(LEN_P2);
         PH_BN2:  w_len = 5'(LEN_P3);
         PH_LV2:  w_len = 5'(LEN_P4);
         PH_BN3:  w_len = 5'(LEN_P5);
         PH_LV3:  w_len = 5'(LEN_P6);
         default: w_len = 5'd0;
      endcase
   end

   // Row counter control mirrors the FSM decisions below; clr+en restarts
   // the counter at row 1 when moving into the next phase.
   always_comb begin
      w_cnt_clr = 1'b0;
      w_cnt_en  = 1'b0;
      case (r_state)
         ST_IDLE, ST_WIN: w_cnt_clr = CC_LEVELSEQUENCER_Start_In;
         ST_RUN: begin
            if (CC_LEVELSEQUENCER_Crash_In) begin
               w_cnt_clr = 1'b1;
            end else if (w_tick_ok) begin
               if (!w_tc) begin
                  w_cnt_en = 1'b1;
               end else begin
                  w_cnt_clr = 1'b1;
                  w_cnt_en  = (r_current < PH_LV3);
               end
            end
         end
         ST_CRASH: w_cnt_clr = w_tick_ok && (r_crash_cnt == HOLD_LAST);
         default: ;
      endcase
   end

   cc_level_sequencer_row_counter u_row_counter (
      .i_clk   (CC_LEVELSEQUENCER_CLOCK_50),
      .i_rst_n (CC_LEVELSEQUENCER_RESET_InLow),
      .i_clr   (w_cnt_clr),
      .i_en    (w_cnt_en),
      .i_len   (w_len),
      .o_count (w_count),
      .o_tc    (w_tc)
   );

   always_ff @(posedge CC_LEVELSEQUENCER_CLOCK_50 or negedge CC_LEVELSEQUENCER_RESET_InLow) begin
      if (!CC_LEVELSEQUENCER_RESET_InLow) begin
         r_state      <= ST_IDLE;
         r_current    <= PH_NONE;
         r_crash_cnt  <= 4'd0;
         r_row_load   <= 1'b0;
         r_phase_done <= 1'b0;
         r_win        <= 1'b0;
      end else begin
         r_row_load   <= 1'b0;
         r_phase_done <= 1'b0;
         case (r_state)
            ST_IDLE, ST_WIN: begin
               if (CC_LEVELSEQUENCER_Start_In) begin
                  r_state     <= ST_RUN;
                  r_current   <= PH_BN1;
                  r_crash_cnt <= 4'd0;
                  r_win       <= 1'b0;
               end
            end
            ST_RUN: begin
               if (CC_LEVELSEQUENCER_Crash_In) begin
                  r_state     <= ST_CRASH;
                  r_crash_cnt <= 4'd0;
               end else if (w_tick_ok) begin
                  if (!w_tc) begin
                     r_row_load <= 1'b1;
                  end else if (r_current < PH_LV3) begin
                     r_current    <= r_current + 3'd1;
                     r_row_load   <= 1'b1;
                     r_phase_done <= 1'b1;
                  end else begin
                     r_state      <= ST_WIN;
                     r_current    <= PH_NONE;
                     r_phase_done <= 1'b1;
                     r_win        <= 1'b1;
                  end
               end
            end
            ST_CRASH: begin
               if (w_tick_ok) begin
                  if (r_crash_cnt == HOLD_LAST) begin
                     r_state     <= ST_RUN;
                     r_current   <= replay_phase(r_current);
                     r_crash_cnt <= 4'd0;
                  end else begin
                     r_crash_cnt <= r_crash_cnt + 4'd1;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign CC_LEVELSEQUENCER_Current_Out   = r_current;
   assign CC_LEVELSEQUENCER_Progress_Out  = w_count;
   assign CC_LEVELSEQUENCER_RowLoad_Out   = r_row_load;
   assign CC_LEVELSEQUENCER_PhaseDone_Out = r_phase_done;
   assign CC_LEVELSEQUENCER_Win_Out       = r_win;

endmodule

// File: tb/tb_cc_level_sequencer.sv
module tb_cc_level_sequencer;

   localparam int HOLD = 4;
   localparam int M_IDLE = 0, M_RUN = 1, M_CRASH = 2, M_WIN = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tick = 1'b0, start = 1'b0, pause = 1'b0, crash = 1'b0;
   logic [2:0] cur;
   logic [4:0] prog;
   logic       rl, pd, win;

   always #5 clk = ~clk;

   cc_level_sequencer #(
      .LEN_P1(8), .LEN_P2(10), .LEN_P3(8), .LEN_P4(15), .LEN_P5(8), .LEN_P6(20),
      .CRASH_HOLD(HOLD)
   ) dut (
      .CC_LEVELSEQUENCER_CLOCK_50      (clk),
      .CC_LEVELSEQUENCER_RESET_InLow   (rst_n),
      .CC_LEVELSEQUENCER_Tick_In       (tick),
      .CC_LEVELSEQUENCER_Start_In      (start),
      .CC_LEVELSEQUENCER_Pause_In      (pause),
      .CC_LEVELSEQUENCER_Crash_In      (crash),
      .CC_LEVELSEQUENCER_Current_Out   (cur),
      .CC_LEVELSEQUENCER_Progress_Out  (prog),
      .CC_LEVELSEQUENCER_RowLoad_Out   (rl),
      .CC_LEVELSEQUENCER_PhaseDone_Out (pd),
      .CC_LEVELSEQUENCER_Win_Out       (win)
   );

   typedef struct packed {
      logic [2:0] cur;
      logic [4:0] prog;
      logic       rl;
      logic       pd;
      logic       win;
   } exp_t;

   exp_t q[$];
   int   n_pass = 0;
   int   n_total = 0;

   // Reference model: track position as plain integers.
   int lens[7] = '{0, 8, 10, 8, 15, 8, 20};
   int m_mode = M_IDLE, m_phase = 0, m_row = 0, m_hold = 0;

   function automatic exp_t model_step(input bit t, input bit s, input bit p, input bit c);
      exp_t e;
      bit   e_rl = 0, e_pd = 0;
      case (m_mode)
         M_IDLE, M_WIN: if (s) begin m_mode = M_RUN; m_phase = 1; m_row = 0; end
         M_RUN: begin
            if (c) begin
               m_mode = M_CRASH; m_row = 0; m_hold = 0;
            end else if (t && !p) begin
               if (m_row < lens[m_phase]) begin
                  m_row++; e_rl = 1;
               end else if (m_phase < 6) begin
                  m_phase++; m_row = 1; e_rl = 1; e_pd = 1;
               end else begin
                  m_mode = M_WIN; m_phase = 0; m_row = 0; e_pd = 1;
               end
            end
         end
         default: begin
            if (t && !p) begin
               m_hold++;
               if (m_hold == HOLD) begin
                  m_mode = M_RUN; m_row = 0;
                  if (m_phase % 2 == 0) m_phase--;
               end
            end
         end
      endcase
      e.cur = 3'(m_phase); e.prog = 5'(m_row); e.rl = e_rl; e.pd = e_pd;
      e.win = (m_mode == M_WIN);
      return e;
   endfunction

   task automatic drive(input bit t, input bit s, input bit p, input bit c);
      @(negedge clk);
      tick = t; start = s; pause = p; crash = c;
      q.push_back(model_step(t, s, p, c));
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         drive(1, 0, 0, 0);
         drive(0, 0, 0, 0);
      end
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // Direct check of the DUT against spec constants, after the last drive's edge.
   task automatic check_now(input string name, input int c, input int pr, input int r, input int d, input int w);
      @(posedge clk); #2;
      check({name, ".cur"}, int'(cur), c);
      check({name, ".prog"}, int'(prog), pr);
      check({name, ".rowload"}, int'(rl), r);
      check({name, ".phasedone"}, int'(pd), d);
      check({name, ".win"}, int'(win), w);
   endtask

   // Monitor: compares every clocked response with the scoreboard entry.
   initial begin
      exp_t e, a;
      forever begin
         @(posedge clk); #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            a = '{cur, prog, rl, pd, win};
            n_total++;
            if (a == e) n_pass++;
            else $display("FAIL cycle_outputs @%0t: got cur=%0d prog=%0d rl=%0d pd=%0d win=%0d expected cur=%0d prog=%0d rl=%0d pd=%0d win=%0d",
                          $time, a.cur, a.prog, a.rl, a.pd, a.win, e.cur, e.prog, e.rl, e.pd, e.win);
         end
      end
   end

   initial begin
      repeat (3) @(posedge clk);
      #2;
      check("reset.cur", int'(cur), 0);
      check("reset.prog", int'(prog), 0);
      check("reset.rowload", int'(rl), 0);
      check("reset.win", int'(win), 0);
      @(negedge clk); rst_n = 1'b1;

      // Ticks in IDLE are ignored; start, first row.
      ticks(2);
      drive(0, 1, 0, 0);
      check_now("start", 1, 0, 0, 0, 0);
      drive(1, 0, 0, 0);
      check_now("first_tick", 1, 1, 1, 0, 0);
      drive(0, 0, 0, 0);

      // Phase 1 boundary.
      ticks(7);
      drive(1, 0, 0, 0);
      check_now("phase1_to_2", 2, 1, 1, 1, 0);
      drive(0, 0, 0, 0);

      // Pause across 3 ticks, then one more tick.
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 1, 0);
         drive(0, 0, 1, 0);
      end
      drive(1, 0, 0, 0);
      check_now("after_pause", 2, 2, 1, 0, 0);

      // Run to phase 4 row 7, crash with a simultaneous tick.
      while (!(m_phase == 4 && m_row == 7)) ticks(1);
      drive(1, 0, 0, 1);
      check_now("crash_entry", 4, 0, 0, 0, 0);
      drive(0, 1, 0, 1);            // start and crash both ignored in CRASH
      drive(1, 0, 1, 0);            // paused tick not counted
      ticks(3);
      check_now("crash_hold3", 4, 0, 0, 0, 0);
      drive(1, 0, 0, 0);
      check_now("crash_replay", 3, 0, 0, 0, 0);

      // Run to the last row of phase 6, then win.
      while (!(m_phase == 6 && m_row == 20)) ticks(1);
      drive(1, 0, 0, 0);
      check_now("win", 0, 0, 0, 1, 1);
      ticks(3);

      // Restart from WIN, run to phase 6 row 12, reset mid-cycle on the strobe.
      drive(0, 1, 0, 0);
      while (!(m_phase == 6 && m_row == 11)) ticks(1);
      drive(1, 0, 0, 0);
      @(posedge clk); #2;
      check("pre_reset.prog", int'(prog), 12);
      check("pre_reset.rowload", int'(rl), 1);
      #1 rst_n = 1'b0;
      #1;
      check("async_reset.cur", int'(cur), 0);
      check("async_reset.prog", int'(prog), 0);
      check("async_reset.rowload", int'(rl), 0);
      m_mode = M_IDLE; m_phase = 0; m_row = 0; m_hold = 0;
      tick = 0; start = 0; pause = 0; crash = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      ticks(2);
      drive(0, 1, 0, 0);
      drive(1, 0, 0, 0);
      check_now("resume", 1, 1, 1, 0, 0);

      // Randomized play.
      for (int i = 0; i < 6000; i++) begin
         drive(($urandom % 3) != 0, ($urandom % 40) == 0,
               ($urandom % 10) == 0, ($urandom % 150) == 0);
      end
      drive(0, 0, 0, 0);
      @(posedge clk); #3;
      check("scoreboard_drained", q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
